// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if - bus bundle between the interrupt controller and its host.
//   src        : asynchronous level interrupt sources
//   mask_wr    : one-cycle mask write strobe
//   mask_wdata : mask write data (1 = source masked)
//   mask       : current mask register
//   pending    : latched pending bits (reported regardless of mask)
//   irq        : interrupt request to the processor
//   irq_id     : index of the source being serviced, valid while irq=1
//   ack        : one-cycle acknowledge from the handler
// slave modport is the controller side, master is the host/processor side.
interface irq_ctrl_if #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 2
);
  logic [NUM_SRC-1:0] src;
  logic               mask_wr;
  logic [NUM_SRC-1:0] mask_wdata;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] pending;
  logic               irq;
  logic [ID_W-1:0]    irq_id;
  logic               ack;

  modport slave (
    input  src, mask_wr, mask_wdata, ack,
    output mask, pending, irq, irq_id
  );

  modport master (
    output src, mask_wr, mask_wdata, ack,
    input  mask, pending, irq, irq_id
  );
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl - fixed-priority interrupt controller.
// Sources are synchronized (2 flops), rising-edge detected and latched into
// pending bits. Eligible = pending & ~mask; the lowest eligible index is
// served, one at a time, with a mandatory low gap between interrupts.
// Ports:
//   clk : clock, all flops on rising edge
//   rst : asynchronous active-high reset
//   bus : irq_ctrl_if.slave (src, mask_wr, mask_wdata, ack in;
//         mask, pending, irq, irq_id out)
//
// state    | meaning
// S_IDLE   | no interrupt in service; arbitrate eligible sources
// S_ACTIVE | irq=1, irq_id held; waiting for ack
// S_GAP    | one forced irq=0 cycle after an ack
module irq_ctrl #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 2
) (
  input  logic       clk,
  input  logic       rst,
  irq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_SRC-1:0] r_sync1;
  logic [NUM_SRC-1:0] r_sync2;
  logic [NUM_SRC-1:0] r_prev;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_mask;
  logic               r_irq;
  logic [ID_W-1:0]    r_irq_id;

  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_clr;
  logic [NUM_SRC-1:0] w_elig;
  logic [ID_W-1:0]    w_low;
  logic               w_any;
  logic               w_irq_nxt;
  logic [ID_W-1:0]    w_irq_id_nxt;

  assign w_rise = r_sync2 & ~r_prev;
  assign w_elig = r_pending & ~r_mask;
  assign w_any  = |w_elig;

  // Only an ack seen while in service clears the bit being serviced.
  assign w_clr = (r_state == S_ACTIVE && bus.ack) ?
                 (NUM_SRC'(1) << r_irq_id) : '0;

  // Lowest set index wins: scan downward so the last hit is the lowest.
  always_comb begin
    w_low = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_elig[i]) w_low = ID_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_prev    <= '0;
      r_pending <= '0;
      r_mask    <= '0;
    end else begin
      r_sync1   <= bus.src;
      r_sync2   <= r_sync1;
      r_prev    <= r_sync2;
      // Set has priority over a coincident clear.
      r_pending <= (r_pending & ~w_clr) | w_rise;
      if (bus.mask_wr) r_mask <= bus.mask_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_irq    <= 1'b0;
      r_irq_id <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_irq    <= w_irq_nxt;
      r_irq_id <= w_irq_id_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_irq_nxt    = r_irq;
    w_irq_id_nxt = r_irq_id;
    case (r_state)
      S_IDLE: begin
        w_irq_nxt = 1'b0;
        if (w_any) begin
          w_irq_id_nxt = w_low;
          w_irq_nxt    = 1'b1;
          w_state_nxt  = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (bus.ack) begin
          w_irq_nxt   = 1'b0;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        w_irq_nxt   = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_irq_nxt   = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.mask    = r_mask;
  assign bus.pending = r_pending;
  assign bus.irq     = r_irq;
  assign bus.irq_id  = r_irq_id;

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_fail = 0;
  int   n_hi;

  irq_ctrl_if #(.NUM_SRC(4), .ID_W(2)) bus ();

  irq_ctrl #(.NUM_SRC(4), .ID_W(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.src        = 4'b0000;
    bus.mask_wr    = 1'b0;
    bus.mask_wdata = 4'b0000;
    bus.ack        = 1'b0;

    // reset state
    tick; tick;
    check("rst_mask", 32'(bus.mask), 32'h0);
    check("rst_pending", 32'(bus.pending), 32'h0);
    check("rst_irq", 32'(bus.irq), 32'h0);
    check("rst_irq_id", 32'(bus.irq_id), 32'h0);
    rst = 1'b0;
    tick; tick;

    // single source, latency
    bus.src = 4'b0100;
    tick;                                   // E0
    tick;                                   // E1
    check("s1_pend_e1", 32'(bus.pending), 32'h0);
    tick;                                   // E2
    check("s1_pend_e2", 32'(bus.pending), 32'h4);
    check("s1_irq_e2", 32'(bus.irq), 32'h0);
    tick;                                   // E3
    check("s1_irq_e3", 32'(bus.irq), 32'h1);
    check("s1_id_e3", 32'(bus.irq_id), 32'h2);
    bus.src = 4'b0000;
    bus.ack = 1'b1;
    tick;
    bus.ack = 1'b0;
    check("s1_pend_ack", 32'(bus.pending), 32'h0);
    check("s1_irq_ack", 32'(bus.irq), 32'h0);
    tick; tick;

    // priority
    bus.src = 4'b1010;
    tick; tick; tick;
    check("pr_pend", 32'(bus.pending), 32'ha);
    tick;
    check("pr_irq1", 32'(bus.irq), 32'h1);
    check("pr_id1", 32'(bus.irq_id), 32'h1);
    bus.ack = 1'b1;
    tick;
    bus.ack = 1'b0;
    check("pr_pend_after1", 32'(bus.pending), 32'h8);
    check("pr_irq_gap", 32'(bus.irq), 32'h0);
    tick;
    check("pr_irq_idle", 32'(bus.irq), 32'h0);
    tick;
    check("pr_irq2", 32'(bus.irq), 32'h1);
    check("pr_id2", 32'(bus.irq_id), 32'h3);
    bus.ack = 1'b1;
    tick;
    bus.ack = 1'b0;
    check("pr_pend_after2", 32'(bus.pending), 32'h0);
    bus.src = 4'b0000;
    tick; tick; tick;

    // masking
    bus.mask_wr    = 1'b1;
    bus.mask_wdata = 4'b0001;
    tick;
    bus.mask_wr    = 1'b0;
    check("mk_mask", 32'(bus.mask), 32'h1);
    bus.src = 4'b0001;
    tick; tick; tick; tick;
    check("mk_pend", 32'(bus.pending), 32'h1);
    check("mk_irq_masked", 32'(bus.irq), 32'h0);
    bus.src = 4'b0000;
    tick; tick; tick;
    check("mk_irq_still", 32'(bus.irq), 32'h0);
    bus.mask_wr    = 1'b1;
    bus.mask_wdata = 4'b0000;
    tick;
    bus.mask_wr    = 1'b0;
    check("mk_mask0", 32'(bus.mask), 32'h0);
    check("mk_irq_w1", 32'(bus.irq), 32'h0);
    tick;
    check("mk_irq_w2", 32'(bus.irq), 32'h1);
    check("mk_id_w2", 32'(bus.irq_id), 32'h0);

    // set/clear collision on source 0
    bus.src = 4'b0001;
    tick; tick;
    bus.ack = 1'b1;
    tick;
    bus.ack = 1'b0;
    check("co_pend", 32'(bus.pending), 32'h1);
    check("co_irq_gap", 32'(bus.irq), 32'h0);
    tick;
    check("co_irq_idle", 32'(bus.irq), 32'h0);
    tick;
    check("co_irq_re", 32'(bus.irq), 32'h1);
    check("co_id_re", 32'(bus.irq_id), 32'h0);
    bus.ack = 1'b1;
    tick;
    bus.ack = 1'b0;
    check("co_pend_clr", 32'(bus.pending), 32'h0);
    bus.src = 4'b0000;
    tick; tick; tick; tick;

    // held level and stray ack
    bus.src = 4'b0010;
    tick; tick; tick; tick;
    check("hl_irq", 32'(bus.irq), 32'h1);
    check("hl_id", 32'(bus.irq_id), 32'h1);
    bus.ack = 1'b1;
    tick;
    bus.ack = 1'b0;
    check("hl_pend_ack", 32'(bus.pending), 32'h0);
    n_hi = 0;
    for (int i = 0; i < 16; i++) begin
      tick;
      if (bus.irq) n_hi++;
    end
    check("hl_no_repeat", 32'(n_hi), 32'h0);
    check("hl_pend_held", 32'(bus.pending), 32'h0);
    bus.ack = 1'b1;
    tick;
    bus.ack = 1'b0;
    check("sa_irq", 32'(bus.irq), 32'h0);
    check("sa_pend", 32'(bus.pending), 32'h0);
    tick;
    check("sa_irq2", 32'(bus.irq), 32'h0);
    bus.src = 4'b0000;
    tick; tick; tick;

    // reset mid-ACTIVE
    bus.mask_wr    = 1'b1;
    bus.mask_wdata = 4'b0100;
    tick;
    bus.mask_wr    = 1'b0;
    check("ra_mask", 32'(bus.mask), 32'h4);
    bus.src = 4'b0001;
    tick; tick; tick; tick;
    check("ra_irq_pre", 32'(bus.irq), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("ra_irq", 32'(bus.irq), 32'h0);
    check("ra_pend", 32'(bus.pending), 32'h0);
    check("ra_mask0", 32'(bus.mask), 32'h0);
    tick;
    rst = 1'b0;

    // source already high at reset release
    tick; tick;
    check("rr_pend_early", 32'(bus.pending), 32'h0);
    tick;
    check("rr_pend", 32'(bus.pending), 32'h1);
    check("rr_irq_early", 32'(bus.irq), 32'h0);
    tick;
    check("rr_irq", 32'(bus.irq), 32'h1);
    check("rr_id", 32'(bus.irq_id), 32'h0);
    bus.ack = 1'b1;
    tick;
    bus.ack = 1'b0;
    check("rr_pend_clr", 32'(bus.pending), 32'h0);
    bus.src = 4'b0000;
    tick; tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
